// File: rtl/a2d_chnl_sequencer_pkg.sv
// a2d_chnl_sequencer_pkg: FSM state type and default parameters shared by the channel sequencer and its button front end
package a2d_chnl_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
    localparam int DEF_NUM_CHNL = 7;
    localparam int DEF_RES_W    = 12;
    localparam int DEF_LED_W    = 8;
    localparam int DEF_SYNC_STG = 3;
    localparam int DEF_LOCKOUT  = 16;
    localparam int DEF_SCAN_DIV = 1024;
    localparam int DEF_TMO_CYC  = 4096;
    function automatic int ch_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync: synchronizes the async push-button, detects 0->1 presses and ignores presses for LOCKOUT cycles after one is accepted
//   clk, rst : clock, synchronous active-high reset
//   next_byte: raw asynchronous button
//   press    : one-cycle pulse per accepted press
module btn_edge_sync
    import a2d_chnl_sequencer_pkg::*;
#(
    parameter int SYNC_STG = DEF_SYNC_STG,
    parameter int LOCKOUT  = DEF_LOCKOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic next_byte,
    output logic press
);
    localparam int LK_W = $clog2(LOCKOUT + 1);
    logic [SYNC_STG-1:0] sync;
    logic [LK_W-1:0]     lock;
    logic                rise;
    // sync[SYNC_STG-1] is the oldest sample; a rise is the newer stage at 1 while the last stage is still 0
    assign rise  = sync[SYNC_STG-2] & ~sync[SYNC_STG-1];
    assign press = rise && lock == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
            lock <= '0;
        end else begin
            sync <= {sync[SYNC_STG-2:0], next_byte};
            lock <= press ? LK_W'(LOCKOUT) : (lock != '0 ? lock - 1'b1 : lock);
        end
    end
endmodule

// File: rtl/a2d_chnl_sequencer.sv
// a2d_chnl_sequencer: steps through A2D channels on button presses or a periodic scan, requests conversions and shows results on LEDs
//   clk, rst          : clock, synchronous active-high reset
//   next_byte         : async push-button (manual step)
//   auto_mode         : 1 = periodic scan, 0 = button-stepped
//   cnv_cmplt, res    : conversion-done pulse and its result
//   strt_cnv, chnnl   : one-cycle conversion request and the channel it targets
//   LEDs              : top LED_W bits of the last completed result
//   busy, timeout_err : conversion in flight, sticky timeout flag
module a2d_chnl_sequencer
    import a2d_chnl_sequencer_pkg::*;
#(
    parameter int NUM_CHNL = DEF_NUM_CHNL,
    parameter int RES_W    = DEF_RES_W,
    parameter int LED_W    = DEF_LED_W,
    parameter int SYNC_STG = DEF_SYNC_STG,
    parameter int LOCKOUT  = DEF_LOCKOUT,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    parameter int TMO_CYC  = DEF_TMO_CYC,
    localparam int CH_W    = ch_w(NUM_CHNL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             next_byte,
    input  logic             auto_mode,
    input  logic             cnv_cmplt,
    input  logic [RES_W-1:0] res,
    output logic             strt_cnv,
    output logic [CH_W-1:0]  chnnl,
    output logic [LED_W-1:0] LEDs,
    output logic             busy,
    output logic             timeout_err
);
    localparam int SC_W = $clog2(SCAN_DIV);
    localparam int TM_W = $clog2(TMO_CYC);
    state_t          state;
    logic [SC_W-1:0] scan;
    logic [TM_W-1:0] tmo;
    logic            press;
    logic            tick;
    logic            trig;
    logic            unused_res;
    assign unused_res = ^res;
    btn_edge_sync #(.SYNC_STG(SYNC_STG), .LOCKOUT(LOCKOUT)) u_btn (
        .clk       (clk),
        .rst       (rst),
        .next_byte (next_byte),
        .press     (press)
    );
    // presses are ignored in auto mode, so a coincident press and tick collapse to one trigger
    assign tick = auto_mode && scan == SC_W'(SCAN_DIV - 1);
    assign trig = auto_mode ? tick : press;
    always_ff @(posedge clk) begin
        if (rst || !auto_mode || tick)
            scan <= '0;
        else
            scan <= scan + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            chnnl       <= '0;
            strt_cnv    <= 1'b0;
            busy        <= 1'b0;
            LEDs        <= '0;
            timeout_err <= 1'b0;
            tmo         <= '0;
        end else begin
            strt_cnv <= 1'b0;
            case (state)
                IDLE: if (trig) begin
                    chnnl    <= chnnl == CH_W'(NUM_CHNL - 1) ? '0 : chnnl + 1'b1;
                    strt_cnv <= 1'b1;
                    busy     <= 1'b1;
                    state    <= START;
                end
                START: begin
                    tmo   <= '0;
                    state <= WAIT;
                end
                WAIT: if (cnv_cmplt) begin
                    LEDs  <= res[RES_W-1 -: LED_W];
                    busy  <= 1'b0;
                    state <= IDLE;
                end else if (tmo == TM_W'(TMO_CYC - 1)) begin
                    timeout_err <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end else begin
                    tmo <= tmo + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_a2d_chnl_sequencer.sv
// tb_a2d_chnl_sequencer: randomized scoreboard bench for the A2D channel sequencer
module tb_a2d_chnl_sequencer;
    localparam int NC  = 7;
    localparam int SD  = 8;
    localparam int TMO = 20;
    typedef struct {int ch; int gap;} ch_e_t;
    typedef struct {int led; int tmo; int len;} done_e_t;
    logic        clk = 0;
    logic        rst = 1;
    logic        next_byte = 0;
    logic        auto_mode = 0;
    logic        cnv_cmplt = 0;
    logic [11:0] res = '0;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic [7:0]  LEDs;
    logic        busy;
    logic        timeout_err;
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    ch_e_t   ch_q[$];
    done_e_t done_q[$];
    int exp_ch = 0;
    int exp_led = 0;
    int exp_tmo = 0;
    int resp_mode = 0;
    int resp_lat = 1;
    int force_res = -1;
    a2d_chnl_sequencer #(
        .NUM_CHNL(NC), .RES_W(12), .LED_W(8), .SYNC_STG(3),
        .LOCKOUT(16), .SCAN_DIV(SD), .TMO_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .next_byte(next_byte), .auto_mode(auto_mode),
        .cnv_cmplt(cnv_cmplt), .res(res), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .LEDs(LEDs), .busy(busy), .timeout_err(timeout_err)
    );
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic press(input int hold);
        next_byte = 1;
        idle(hold);
        next_byte = 0;
    endtask
    task automatic expect_trigger(input int gap);
        exp_ch = (exp_ch + 1) % NC;
        ch_q.push_back('{exp_ch, gap});
    endtask
    task automatic clean_press(input int hold);
        resp_lat = $urandom_range(1, 3);
        expect_trigger(0);
        press(hold);
        idle(40);
    endtask
    // A2D model: answers each request after resp_lat cycles, or stays silent
    initial forever begin
        @(negedge clk);
        if (!rst && strt_cnv) begin
            if (resp_mode == 0) begin
                int r;
                r = force_res >= 0 ? force_res : int'($urandom_range(0, 4095));
                force_res = -1;
                repeat (resp_lat) @(posedge clk);
                #1;
                cnv_cmplt = 1;
                res = 12'(r);
                exp_led = r / 16;
                done_q.push_back('{exp_led, exp_tmo, 1 + resp_lat});
                @(posedge clk);
                #1;
                cnv_cmplt = 0;
            end else if (resp_mode == 1) begin
                exp_tmo = 1;
                done_q.push_back('{exp_led, 1, 1 + TMO});
            end
        end
    end
    // monitor: pops on each strt_cnv and on each end of busy
    initial begin
        int prev_busy = 0;
        int prev_strt = 0;
        int blen = 0;
        int last_strt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 0;
                prev_strt = 0;
                blen = 0;
            end else begin
                if (busy) blen++;
                if (strt_cnv) begin
                    if (prev_strt) check("strt_width", 2, 1);
                    if (ch_q.size() == 0) begin
                        check("unexpected_strt", 1, 0);
                    end else begin
                        ch_e_t e;
                        e = ch_q.pop_front();
                        check("chnnl", int'(chnnl), e.ch);
                        check("busy_at_strt", int'(busy), 1);
                        if (e.gap != 0) check("scan_gap", cyc - last_strt, e.gap);
                    end
                    last_strt = cyc;
                end
                if (prev_busy == 1 && !busy) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        done_e_t d;
                        d = done_q.pop_front();
                        check("LEDs", int'(LEDs), d.led);
                        check("timeout_err", int'(timeout_err), d.tmo);
                        check("busy_len", blen, d.len);
                    end
                    blen = 0;
                end
                prev_busy = int'(busy);
                prev_strt = int'(strt_cnv);
            end
        end
    end
    initial begin
        idle(4);
        @(negedge clk);
        check("rst_strt", int'(strt_cnv), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_chnnl", int'(chnnl), 0);
        check("rst_LEDs", int'(LEDs), 0);
        check("rst_tmo", int'(timeout_err), 0);
        @(posedge clk);
        #1;
        rst = 0;
        idle(10);
        for (int i = 0; i < 3; i++) clean_press(2);
        for (int i = 0; i < 6; i++) clean_press($urandom_range(1, 6));
        while (exp_ch != NC - 1) clean_press($urandom_range(1, 4));
        force_res = 12'hABC;
        clean_press(3);
        check("chnnl_wrap", int'(chnnl), 0);
        check("LEDs_ABC", int'(LEDs), 8'hAB);
        // bouncing button: three rising edges, one accepted
        resp_lat = $urandom_range(1, 3);
        expect_trigger(0);
        for (int i = 0; i < 5; i++) begin
            next_byte = ~next_byte;
            idle(2);
        end
        next_byte = 0;
        idle(40);
        // timeout with a press dropped during WAIT
        resp_mode = 1;
        expect_trigger(0);
        press(3);
        idle(15);
        press(3);
        idle(50);
        check("tmo_sticky", int'(timeout_err), 1);
        resp_mode = 0;
        clean_press(2);
        // auto scan
        resp_lat = 2;
        for (int n = 0; n < 9; n++) expect_trigger(n == 0 ? 0 : SD);
        auto_mode = 1;
        idle(SD * 9 + 4);
        auto_mode = 0;
        idle(20);
        // reset during WAIT, then a late completion
        resp_mode = 2;
        expect_trigger(0);
        press(2);
        idle(10);
        rst = 1;
        idle(2);
        rst = 0;
        exp_ch = 0;
        exp_led = 0;
        exp_tmo = 0;
        cnv_cmplt = 1;
        res = 12'hFFF;
        idle(1);
        cnv_cmplt = 0;
        @(negedge clk);
        check("abort_LEDs", int'(LEDs), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_chnnl", int'(chnnl), 0);
        check("abort_tmo", int'(timeout_err), 0);
        check("abort_strt", int'(strt_cnv), 0);
        @(posedge clk);
        #1;
        idle(20);
        resp_mode = 0;
        clean_press(2);
        check("ch_q_empty", ch_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
